// File: rtl/anc_pkg.sv
// rtl/anc_pkg.sv - shared widths and FSM encoding for the ANC sequencer
package anc_pkg;

  // Q1.15 sample width and full err*mu product width
  localparam int QW = 16;
  localparam int PW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    GO   = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/saturate.sv
// rtl/saturate.sv - signed saturation from IW bits down to OW bits
module saturate #(
  parameter int IW = 17,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout
);

  localparam logic signed [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};

  // Bits that must all agree with the output sign bit for the value to fit
  logic [IW-OW:0] top;
  assign top = din[IW-1:OW-1];

  // Pass through when the dropped bits are pure sign extension, else clamp
  always_comb begin
    dout = din[OW-1:0];
    if (!(&top) && (|top)) begin
      dout = din[IW-1] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/anc_ctrl.sv
// rtl/anc_ctrl.sv - per-frame LMS step and FIR launch sequencer with pending slot and watchdog
module anc_ctrl
  import anc_pkg::*;
#(
  parameter int TAPS    = 256,
  parameter int TIMEOUT = 2 * TAPS,
  parameter int TW      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic signed [QW-1:0] ref_in,
  input  logic signed [QW-1:0] err_in,
  input  logic signed [QW-1:0] offset_in,
  input  logic signed [QW-1:0] mu,
  output logic signed [QW-1:0] x_in,
  output logic signed [QW-1:0] a_in,
  output logic signed [QW-1:0] weight_adjust,
  output logic                 fir_go,
  input  logic                 fir_done,
  input  logic signed [QW-1:0] fir_out,
  output logic signed [QW-1:0] anti_noise,
  output logic                 anti_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err
);

  state_t               state;
  logic signed [QW-1:0] ref_r, off_r;
  logic signed [PW-1:0] prod_r;
  logic signed [QW-1:0] pend_ref, pend_err, pend_off, pend_mu;
  logic                 pend_v;
  logic [TW-1:0]        wd_cnt;

  logic                 take_new;
  logic signed [QW-1:0] src_ref, src_err, src_off, src_mu;
  logic signed [PW-1:0] prod_next;
  logic signed [QW-1:0] step_sat;
  logic                 prod_lsb_unused;

  assign take_new = sample_valid && enable;

  // A queued sample always wins over a live one in IDLE
  assign src_ref = pend_v ? pend_ref : ref_in;
  assign src_err = pend_v ? pend_err : err_in;
  assign src_off = pend_v ? pend_off : offset_in;
  assign src_mu  = pend_v ? pend_mu  : mu;

  // Product is registered on entry to CALC so the saturated step can be
  // registered at the end of CALC and be stable alongside fir_go
  assign prod_next = src_err * src_mu;

  // Q1.15 * Q1.15 = Q2.30; bits [31:15] realign to Q1.15 with one guard bit
  saturate #(.IW(PW - QW + 1), .OW(QW)) u_sat (
    .din  (prod_r[PW-1:QW-1]),
    .dout (step_sat)
  );

  // Fractional bits below Q1.15 resolution are intentionally discarded
  assign prod_lsb_unused = ^prod_r[QW-2:0];

  // Sequencer FSM, pending slot, sticky flags and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ref_r         <= '0;
      off_r         <= '0;
      prod_r        <= '0;
      pend_ref      <= '0;
      pend_err      <= '0;
      pend_off      <= '0;
      pend_mu       <= '0;
      pend_v        <= 1'b0;
      wd_cnt        <= '0;
      x_in          <= '0;
      a_in          <= '0;
      weight_adjust <= '0;
      fir_go        <= 1'b0;
      anti_noise    <= '0;
      anti_valid    <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      fir_go     <= 1'b0;
      anti_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (pend_v || take_new) begin
            ref_r  <= src_ref;
            off_r  <= src_off;
            prod_r <= prod_next;
            state  <= CALC;
            busy   <= 1'b1;
          end
          // Consuming the slot frees it for a sample arriving this very cycle
          if (pend_v) begin
            pend_v <= take_new;
            if (take_new) begin
              pend_ref <= ref_in;
              pend_err <= err_in;
              pend_off <= offset_in;
              pend_mu  <= mu;
            end
          end
        end
        CALC: begin
          x_in          <= ref_r;
          a_in          <= off_r;
          weight_adjust <= step_sat;
          fir_go        <= 1'b1;
          state         <= GO;
        end
        GO: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (fir_done) begin
            anti_noise <= fir_out;
            anti_valid <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else if (wd_cnt == TW'(TIMEOUT - 2)) begin
            // wd_cnt lags the fir_go cycle by one, so this fires TIMEOUT cycles after fir_go
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Samples arriving mid-pass go to the one-deep slot, or are dropped
      if (state != IDLE && take_new) begin
        if (pend_v) begin
          overrun <= 1'b1;
        end else begin
          pend_v   <= 1'b1;
          pend_ref <= ref_in;
          pend_err <= err_in;
          pend_off <= offset_in;
          pend_mu  <= mu;
        end
      end
    end
  end

endmodule

// File: tb/tb_anc_ctrl.sv
// tb/tb_anc_ctrl.sv - directed self-checking bench for anc_ctrl
module tb_anc_ctrl;

  localparam int TIMEOUT = 512;

  logic               clk = 1'b0;
  logic               rst, enable, sample_valid, fir_done;
  logic signed [15:0] ref_in, err_in, offset_in, mu, fir_out;
  logic signed [15:0] x_in, a_in, weight_adjust, anti_noise;
  logic               fir_go, anti_valid, busy, overrun, timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  anc_ctrl #(.TAPS(256), .TIMEOUT(TIMEOUT), .TW(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sample_valid  (sample_valid),
    .ref_in        (ref_in),
    .err_in        (err_in),
    .offset_in     (offset_in),
    .mu            (mu),
    .x_in          (x_in),
    .a_in          (a_in),
    .weight_adjust (weight_adjust),
    .fir_go        (fir_go),
    .fir_done      (fir_done),
    .fir_out       (fir_out),
    .anti_noise    (anti_noise),
    .anti_valid    (anti_valid),
    .busy          (busy),
    .overrun       (overrun),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe one sample and advance to the GO cycle
  task automatic launch(input logic [15:0] r, input logic [15:0] e,
                        input logic [15:0] o, input logic [15:0] m);
    ref_in = r; err_in = e; offset_in = o; mu = m;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
  endtask

  // Return one FIR result; leaves the bench in the cycle after done
  task automatic done_pulse(input logic [15:0] v);
    fir_out  = v;
    fir_done = 1'b1;
    step();
    fir_done = 1'b0;
  endtask

  // Count fir_go pulses over n cycles
  task automatic count_go(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (fir_go) c++;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; sample_valid = 1'b0; fir_done = 1'b0;
    ref_in = '0; err_in = '0; offset_in = '0; mu = '0; fir_out = '0;
    steps(2);
    check("rst_x_in", x_in, 16'h0000);
    check("rst_a_in", a_in, 16'h0000);
    check("rst_wadj", weight_adjust, 16'h0000);
    check("rst_fir_go", fir_go, 16'h0);
    check("rst_anti_noise", anti_noise, 16'h0000);
    check("rst_anti_valid", anti_valid, 16'h0);
    check("rst_busy", busy, 16'h0);
    check("rst_overrun", overrun, 16'h0);
    check("rst_timeout", timeout_err, 16'h0);
    rst = 1'b0;
    step();

    // Basic pass: 0.5 * 0.25 = 0.125 -> 0x1000
    ref_in = 16'h1000; err_in = 16'h4000; offset_in = 16'h0000; mu = 16'h2000;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("t1_calc_busy", busy, 16'h1);
    check("t1_calc_no_go", fir_go, 16'h0);
    step();
    check("t1_go", fir_go, 16'h1);
    check("t1_x_in", x_in, 16'h1000);
    check("t1_a_in", a_in, 16'h0000);
    check("t1_wadj", weight_adjust, 16'h1000);
    step();
    check("t1_go_one_cycle", fir_go, 16'h0);
    check("t1_x_held", x_in, 16'h1000);
    steps(262);
    done_pulse(16'h1234);
    check("t1_anti_valid", anti_valid, 16'h1);
    check("t1_anti_noise", anti_noise, 16'h1234);
    check("t1_idle", busy, 16'h0);
    step();
    check("t1_anti_valid_drop", anti_valid, 16'h0);
    check("t1_anti_noise_hold", anti_noise, 16'h1234);

    // Saturation: -1 * -1 clamps positive, 0x7FFF * -1 fits exactly
    launch(16'h0000, 16'h8000, 16'h0007, 16'h8000);
    check("t2_sat_pos", weight_adjust, 16'h7FFF);
    check("t2_a_in", a_in, 16'h0007);
    step();
    done_pulse(16'h0001);
    launch(16'h0000, 16'h7FFF, 16'h0000, 16'h8000);
    check("t2_sat_neg", weight_adjust, 16'h8001);
    step();
    done_pulse(16'h0002);
    step();

    // Pending slot and overrun
    launch(16'h0111, 16'h0100, 16'h0000, 16'h7FFF);
    step();
    ref_in = 16'h0222; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("t3_no_overrun", overrun, 16'h0);
    ref_in = 16'h0333; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("t3_overrun", overrun, 16'h1);
    steps(5);
    done_pulse(16'h5555);
    check("t3_anti_valid", anti_valid, 16'h1);
    check("t3_anti_noise", anti_noise, 16'h5555);
    step();
    check("t3_calc_no_go", fir_go, 16'h0);
    step();
    check("t3_pend_go", fir_go, 16'h1);
    check("t3_pend_x_in", x_in, 16'h0222);
    check("t3_pend_wadj", weight_adjust, 16'h00FF);
    step();
    done_pulse(16'h6666);
    check("t3_second_valid", anti_valid, 16'h1);
    count_go(20, cnt);
    check("t3_third_dropped", 16'(cnt), 16'd0);
    check("t3_idle", busy, 16'h0);

    // Watchdog
    launch(16'h0444, 16'h4000, 16'h0000, 16'h4000);
    steps(TIMEOUT - 1);
    check("t4_before_timeout", timeout_err, 16'h0);
    check("t4_still_busy", busy, 16'h1);
    step();
    check("t4_timeout", timeout_err, 16'h1);
    check("t4_idle", busy, 16'h0);
    check("t4_no_valid", anti_valid, 16'h0);
    check("t4_noise_kept", anti_noise, 16'h6666);
    done_pulse(16'h7777);
    check("t4_stray_done", anti_valid, 16'h0);
    check("t4_stray_noise", anti_noise, 16'h6666);
    launch(16'h0555, 16'h4000, 16'h0000, 16'h4000);
    check("t4_relaunch", fir_go, 16'h1);
    check("t4_relaunch_x", x_in, 16'h0555);
    check("t4_relaunch_wadj", weight_adjust, 16'h2000);
    step();
    done_pulse(16'h0ABC);
    check("t4_relaunch_noise", anti_noise, 16'h0ABC);

    // Reset mid-WAIT with a pending sample
    launch(16'h0666, 16'h4000, 16'h0011, 16'h4000);
    step();
    ref_in = 16'h0777; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("t5_x_in", x_in, 16'h0000);
    check("t5_a_in", a_in, 16'h0000);
    check("t5_wadj", weight_adjust, 16'h0000);
    check("t5_anti_noise", anti_noise, 16'h0000);
    check("t5_overrun", overrun, 16'h0);
    check("t5_timeout", timeout_err, 16'h0);
    check("t5_busy", busy, 16'h0);
    check("t5_fir_go", fir_go, 16'h0);
    rst = 1'b0;
    count_go(20, cnt);
    check("t5_no_go_after", 16'(cnt), 16'd0);

    // Enable low
    enable = 1'b0;
    ref_in = 16'h0888; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    count_go(10, cnt);
    check("t6_disabled_go", 16'(cnt), 16'd0);
    check("t6_disabled_busy", busy, 16'h0);
    enable = 1'b1;
    launch(16'h0999, 16'h4000, 16'h0000, 16'h4000);
    check("t6_go", fir_go, 16'h1);
    step();
    enable = 1'b0;
    steps(3);
    done_pulse(16'h0999);
    check("t6_completes", anti_valid, 16'h1);
    check("t6_noise", anti_noise, 16'h0999);
    enable = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
